flex_down_timer: RTL

Parameterised loadable down-counter/timer that counts a programmed value down to zero and reports terminal count, in one-shot or periodic (auto-reload) mode. It is the counting-down counterpart of the up-counting rollover counter used throughout the datapath. Control FSMs use it to issue "wait N enabled cycles" requests and sequence timed phases without their own counters.

---
 rtl/flex_down_timer_if.sv | 26 ++
 rtl/flex_down_timer.sv | 106 ++++++++++
 2 files changed

// File: rtl/flex_down_timer_if.sv
// Control/status bundle for flex_down_timer. The master (a control FSM)
// drives start/abort/enable requests; the slave (the timer) reports the
// remaining count and terminal-count status.
interface flex_down_timer_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    load;
  logic                    count_enable;
  logic                    periodic;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    zero_flag;
  logic                    busy;
  logic                    done;

  modport master (
    output clear, load, count_enable, periodic, load_val,
    input  count_out, zero_flag, busy, done
  );

  modport slave (
    input  clear, load, count_enable, periodic, load_val,
    output count_out, zero_flag, busy, done
  );
endinterface

// File: rtl/flex_down_timer.sv
// Loadable down-counter/timer. Counts a programmed value down to zero on
// enabled cycles and pulses zero_flag at terminal count. In periodic mode
// the count reloads from the last loaded value and keeps running; in
// one-shot mode the timer parks in DONE until the next load or clear.
module flex_down_timer #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  flex_down_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

  state_t                  state_q;
  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] reload_q;
  logic                    zero_q;
  logic                    busy_q;
  logic                    done_q;

  // The terminal step is the enabled RUN cycle that sees a count of one.
  // RUN is never entered with a zero count, so the decrement cannot wrap.
  logic                    terminal_step;
  assign terminal_step = (state_q == RUN) && bus.count_enable && (count_q == CNT_ONE);

  // Timer FSM: state, count, reload value and all status outputs registered
  // together so busy/done/zero_flag change only on the clock edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.clear) begin
      // Abort: reload value is deliberately kept so a later periodic run
      // is unaffected only by an explicit new load.
      state_q <= IDLE;
      count_q <= CNT_ZERO;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.load) begin
      reload_q <= bus.load_val;
      count_q  <= bus.load_val;
      if (bus.load_val != CNT_ZERO) begin
        state_q <= RUN;
        zero_q  <= 1'b0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        // A zero load is an immediate terminal count, even when periodic.
        state_q <= DONE;
        zero_q  <= 1'b1;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end else begin
      zero_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (terminal_step) begin
            zero_q <= 1'b1;
            if (bus.periodic) begin
              count_q <= reload_q;
            end else begin
              count_q <= CNT_ZERO;
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (bus.count_enable) begin
            count_q <= count_q - CNT_ONE;
          end
        end
        DONE: begin
          count_q <= CNT_ZERO;
        end
        IDLE: begin
          // count held, count_enable ignored
        end
        default: begin
          state_q <= IDLE;
          count_q <= CNT_ZERO;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count_out = count_q;
  assign bus.zero_flag = zero_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
